// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - shared slave-index type, error-responder index and region match helper
//
// Contents:
//   N_SLAVES_CFG : slave count the index type is sized for (must be >= data_bus_demux.N_SLAVES)
//   SLV_IDX_W    : width of a slave index, leaving room for ERR_IDX
//   slv_idx_t    : slave index carried through the response-order FIFO
//   ERR_IDX      : all-ones index reserved for the internal error responder
//   in_region()  : inclusive-base / exclusive-end address compare
package data_bus_pkg;

  localparam int N_SLAVES_CFG = 5;
  localparam int SLV_IDX_W    = $clog2(N_SLAVES_CFG + 1);

  typedef logic [SLV_IDX_W-1:0] slv_idx_t;

  localparam slv_idx_t ERR_IDX = '1;

  // Operands are widened to 64 bits by the caller so any ADDR_WIDTH up to 64 works.
  function automatic logic in_region(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] end_addr);
    return (addr >= base) && (addr < end_addr);
  endfunction

endpackage

// File: rtl/data_bus_demux_fifo.sv
// rtl/data_bus_demux_fifo.sv - response-order FIFO of slave indices
//
// Module resp_order_fifo
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   push_i, data_i   : push a slave index (ignored when full)
//   pop_i            : pop the head entry (ignored when empty)
//   head_o           : oldest entry, valid only when !empty_o
//   last_o           : most recently pushed entry, valid only when !empty_o
//   full_o, empty_o  : occupancy flags
//   count_o          : current occupancy
module resp_order_fifo
  import data_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  slv_idx_t         data_i,
  input  logic             pop_i,
  output slv_idx_t         head_o,
  output slv_idx_t         last_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  slv_idx_t         mem [DEPTH];
  slv_idx_t         last_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr];
  assign last_o  = last_q;
  assign count_o = count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
        last_q <= data_i;
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/data_bus_demux.sv
// rtl/data_bus_demux.sv - data-bus demultiplexer from one master to N region-mapped slaves
//
// Optional feature macro: BUS_TIMEOUT_EN (watchdog that errors out hung slave responses).
// Ports:
//   clk_i, rst_i                      : clock, asynchronous active-high reset
//   m_req_i, m_we_i, m_addr_i,
//   m_be_i, m_wdata_i                 : master request
//   m_gnt_o                           : grant to master
//   m_rvalid_o, m_err_o, m_rdata_o    : in-order response to master
//   s_req_o                           : per-slave request, one-hot or zero
//   s_addr_o, s_we_o, s_be_o,
//   s_wdata_o                         : request fields broadcast to all slaves
//   s_gnt_i, s_rvalid_i, s_err_i,
//   s_rdata_i                         : per-slave grant and response
//   outstanding_o                     : response-order FIFO occupancy
//   bus_fault_o                       : sticky decode-error / timeout flag
module data_bus_demux
  import data_bus_pkg::*;
#(
  parameter int                             N_SLAVES        = N_SLAVES_CFG,
  parameter int                             ADDR_WIDTH      = 32,
  parameter int                             DATA_WIDTH      = 32,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE      = '0,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_END       = '0,
  parameter int                             DEFAULT_SLAVE   = 0,
  parameter int                             MAX_OUTSTANDING = 2,
  parameter int                             TIMEOUT_CYCLES  = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               m_req_i,
  input  logic                               m_we_i,
  input  logic [ADDR_WIDTH-1:0]              m_addr_i,
  input  logic [DATA_WIDTH/8-1:0]            m_be_i,
  input  logic [DATA_WIDTH-1:0]              m_wdata_i,
  output logic                               m_gnt_o,
  output logic                               m_rvalid_o,
  output logic                               m_err_o,
  output logic [DATA_WIDTH-1:0]              m_rdata_o,
  output logic [N_SLAVES-1:0]                s_req_o,
  input  logic [N_SLAVES-1:0]                s_gnt_i,
  input  logic [N_SLAVES-1:0]                s_rvalid_i,
  input  logic [N_SLAVES-1:0]                s_err_i,
  output logic [ADDR_WIDTH-1:0]              s_addr_o,
  output logic                               s_we_o,
  output logic [DATA_WIDTH/8-1:0]            s_be_o,
  output logic [DATA_WIDTH-1:0]              s_wdata_o,
  input  logic [N_SLAVES*DATA_WIDTH-1:0]     s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                               bus_fault_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  slv_idx_t sel;
  slv_idx_t sel_slv;
  slv_idx_t head;
  slv_idx_t head_slv;
  slv_idx_t last;
  logic     sel_err;
  logic     can_issue;
  logic     push;
  logic     pop;
  logic     full;
  logic     empty;
  logic     head_err;
  logic     head_real;
  logic     slv_rsp;
  logic     timeout;

  // Lowest-index matching region wins, so scan downwards and let later hits overwrite.
  always_comb begin
    sel = (DEFAULT_SLAVE < N_SLAVES) ? slv_idx_t'(DEFAULT_SLAVE) : ERR_IDX;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (in_region(64'(m_addr_i),
                    64'(SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]),
                    64'(SLAVE_END[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
        sel = slv_idx_t'(i);
      end
    end
  end

  assign sel_err = (sel == ERR_IDX);
  assign sel_slv = sel_err ? '0 : sel;

  // Only one target may be in flight at a time so responses return in order
  // without a reorder buffer. Uses registered occupancy only: no pop->grant path.
  assign can_issue = !full && (empty || (sel == last));
  assign push      = m_req_i && can_issue && (sel_err || s_gnt_i[sel_slv]);
  assign m_gnt_o   = push;

  always_comb begin
    s_req_o = '0;
    if (m_req_i && can_issue && !sel_err) begin
      s_req_o[sel_slv] = 1'b1;
    end
  end

  assign s_addr_o  = m_addr_i;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;

  resp_order_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_order (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .head_o  (head),
    .last_o  (last),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  // An entry only becomes head on a clock edge, so answering an error entry
  // whenever it is head yields the one-cycle-after-grant error response.
  assign head_err  = !empty && (head == ERR_IDX);
  assign head_real = !empty && !head_err;
  assign head_slv  = head_real ? head : '0;
  assign slv_rsp   = head_real && s_rvalid_i[head_slv];

`ifdef BUS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // wd_cnt holds the number of cycles already waited, so the current cycle is
  // the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1.
  assign timeout = head_real && !slv_rsp && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
    end else if (pop || empty) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign pop = slv_rsp || head_err || timeout;

  always_comb begin
    m_rvalid_o = pop;
    m_err_o    = 1'b0;
    m_rdata_o  = '0;
    if (slv_rsp) begin
      m_err_o   = s_err_i[head_slv];
      m_rdata_o = s_rdata_i[head_slv*DATA_WIDTH +: DATA_WIDTH];
    end else if (head_err || timeout) begin
      m_err_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_fault_o <= 1'b0;
    end else if (head_err || timeout) begin
      bus_fault_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_bus_demux.sv
// tb/tb_data_bus_demux.sv - directed table-driven bench for data_bus_demux
module tb_data_bus_demux;

  localparam int NS = 5;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_req, m_we;
  logic [AW-1:0]   m_addr;
  logic [DW/8-1:0] m_be;
  logic [DW-1:0]   m_wdata;
  logic            m_gnt, m_rvalid, m_err;
  logic [DW-1:0]   m_rdata;
  logic [NS-1:0]   s_req, s_gnt, s_rvalid, s_err;
  logic [AW-1:0]   s_addr;
  logic            s_we;
  logic [DW/8-1:0] s_be;
  logic [DW-1:0]   s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [1:0]      outstanding;
  logic            bus_fault;

  always #5 clk = ~clk;

  data_bus_demux #(
    .N_SLAVES        (NS),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .SLAVE_BASE      ({32'h4000, 32'h3000, 32'h1000, 32'h0200, 32'h0300}),
    .SLAVE_END       ({32'h4100, 32'h3100, 32'h2000, 32'h0470, 32'h0500}),
    .DEFAULT_SLAVE   (NS),
    .MAX_OUTSTANDING (2),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m_req_i       (m_req),
    .m_we_i        (m_we),
    .m_addr_i      (m_addr),
    .m_be_i        (m_be),
    .m_wdata_i     (m_wdata),
    .m_gnt_o       (m_gnt),
    .m_rvalid_o    (m_rvalid),
    .m_err_o       (m_err),
    .m_rdata_o     (m_rdata),
    .s_req_o       (s_req),
    .s_gnt_i       (s_gnt),
    .s_rvalid_i    (s_rvalid),
    .s_err_i       (s_err),
    .s_addr_o      (s_addr),
    .s_we_o        (s_we),
    .s_be_o        (s_be),
    .s_wdata_o     (s_wdata),
    .s_rdata_i     (s_rdata),
    .outstanding_o (outstanding),
    .bus_fault_o   (bus_fault)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [4:0]  gnt;
    logic [4:0]  exp_sreq;
    logic        exp_gnt;
  } vec_t;

  vec_t vecs[16];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int          first;
  logic        to_err;
  logic [31:0] to_rdata;

  initial begin
    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_be = 4'hf; m_wdata = '0;
    s_gnt = '0; s_rvalid = '0; s_err = '0; s_rdata = '0;

    // Regions: s0 [300,500) s1 [200,470) s2 [1000,2000) s3 [3000,3100) s4 [4000,4100)
    vecs[0]  = '{1'b0, 32'h0204, 5'h1f, 5'h00, 1'b0};
    vecs[1]  = '{1'b1, 32'h0204, 5'h1f, 5'h02, 1'b1};
    vecs[2]  = '{1'b1, 32'h0204, 5'h00, 5'h02, 1'b0};
    vecs[3]  = '{1'b1, 32'h0400, 5'h1f, 5'h01, 1'b1};
    vecs[4]  = '{1'b1, 32'h0470, 5'h1f, 5'h01, 1'b1};
    vecs[5]  = '{1'b1, 32'h046f, 5'h1e, 5'h01, 1'b0};
    vecs[6]  = '{1'b1, 32'h02ff, 5'h02, 5'h02, 1'b1};
    vecs[7]  = '{1'b1, 32'h1000, 5'h04, 5'h04, 1'b1};
    vecs[8]  = '{1'b1, 32'h1fff, 5'h1b, 5'h04, 1'b0};
    vecs[9]  = '{1'b1, 32'h2000, 5'h00, 5'h00, 1'b1};
    vecs[10] = '{1'b1, 32'h0500, 5'h00, 5'h00, 1'b1};
    vecs[11] = '{1'b1, 32'h4000, 5'h10, 5'h10, 1'b1};
    vecs[12] = '{1'b1, 32'h40ff, 5'h0f, 5'h10, 1'b0};
    vecs[13] = '{1'b1, 32'h3100, 5'h00, 5'h00, 1'b1};
    vecs[14] = '{1'b1, 32'h0200, 5'h02, 5'h02, 1'b1};
    vecs[15] = '{1'b1, 32'h01ff, 5'h1f, 5'h00, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    chk("reset gnt", m_gnt, 0);
    chk("reset rvalid", m_rvalid, 0);
    chk("reset err", m_err, 0);
    chk("reset rdata", m_rdata, 0);
    chk("reset sreq", s_req, 0);
    chk("reset outstanding", outstanding, 0);
    chk("reset fault", bus_fault, 0);
    rst = 1'b0;

    // Decode and grant with an empty FIFO; request dropped before the edge.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      m_req = vecs[i].req; m_addr = vecs[i].addr; s_gnt = vecs[i].gnt;
      #1;
      chk($sformatf("vec%0d sreq", i), s_req, vecs[i].exp_sreq);
      chk($sformatf("vec%0d gnt", i), m_gnt, vecs[i].exp_gnt);
      chk($sformatf("vec%0d saddr", i), s_addr, vecs[i].addr);
      #1 m_req = 1'b0;
    end
    #1 chk("table outstanding", outstanding, 0);

    // Read from slave 1 with one-cycle latency.
    @(negedge clk); m_req = 1'b1; m_addr = 32'h204; s_gnt = 5'h02; #1;
    chk("rd gnt", m_gnt, 1);
    chk("rd sreq", s_req, 5'h02);
    @(negedge clk); m_req = 1'b0; s_rdata[32 +: 32] = 32'hDEADBEEF; s_rvalid = 5'h02; #1;
    chk("rd outstanding1", outstanding, 1);
    chk("rd rvalid", m_rvalid, 1);
    chk("rd rdata", m_rdata, 32'hDEADBEEF);
    chk("rd err", m_err, 0);
    @(negedge clk); s_rvalid = '0; #1;
    chk("rd outstanding0", outstanding, 0);
    chk("rd rvalid idle", m_rvalid, 0);

    // Unmapped access goes to the error responder; stray slave 0 rvalid ignored.
    @(negedge clk); m_req = 1'b1; m_addr = 32'h9000; s_gnt = 5'h1f; #1;
    chk("err gnt", m_gnt, 1);
    chk("err sreq", s_req, 0);
    chk("err no early rvalid", m_rvalid, 0);
    @(negedge clk); m_req = 1'b0; s_rvalid = 5'h01; s_rdata[31:0] = 32'h11111111; #1;
    chk("err rvalid", m_rvalid, 1);
    chk("err err", m_err, 1);
    chk("err rdata", m_rdata, 0);
    @(negedge clk); s_rvalid = '0; #1;
    chk("err fault", bus_fault, 1);
    chk("err outstanding", outstanding, 0);
    chk("err rvalid done", m_rvalid, 0);

    // Three back-to-back reads to slave 0 with depth 2.
    @(negedge clk); m_req = 1'b1; m_addr = 32'h400; s_gnt = 5'h1f; #1;
    chk("b2b gnt1", m_gnt, 1);
    @(negedge clk); #1;
    chk("b2b gnt2", m_gnt, 1);
    @(negedge clk); s_rvalid = 5'h01; s_rdata[31:0] = 32'hA1; #1;
    chk("b2b full", outstanding, 2);
    chk("b2b gnt3 held", m_gnt, 0);
    chk("b2b sreq held", s_req, 0);
    chk("b2b rvalid1", m_rvalid, 1);
    chk("b2b rdata1", m_rdata, 32'hA1);
    @(negedge clk); s_rvalid = '0; #1;
    chk("b2b after pop", outstanding, 1);
    chk("b2b gnt3", m_gnt, 1);
    @(negedge clk); m_req = 1'b0; s_rvalid = 5'h01; s_rdata[31:0] = 32'hA2; #1;
    chk("b2b refill", outstanding, 2);
    chk("b2b rdata2", m_rdata, 32'hA2);
    @(negedge clk); s_rdata[31:0] = 32'hA3; #1;
    chk("b2b rdata3", m_rdata, 32'hA3);
    chk("b2b outstanding1", outstanding, 1);
    @(negedge clk); s_rvalid = '0; #1;
    chk("b2b drained", outstanding, 0);

    // Request to slave 2 stalls while slave 0 has an entry in flight.
    @(negedge clk); m_req = 1'b1; m_addr = 32'h400; #1;
    chk("switch gnt s0", m_gnt, 1);
    @(negedge clk); m_addr = 32'h1000; #1;
    chk("switch stall gnt", m_gnt, 0);
    chk("switch stall sreq", s_req, 0);
    @(negedge clk); s_rvalid = 5'h01; s_rdata[31:0] = 32'hB0; #1;
    chk("switch stall gnt2", m_gnt, 0);
    chk("switch s0 rdata", m_rdata, 32'hB0);
    @(negedge clk); s_rvalid = '0; #1;
    chk("switch gnt s2", m_gnt, 1);
    chk("switch sreq s2", s_req, 5'h04);
    @(negedge clk); m_req = 1'b0; s_rvalid = 5'h05;
    s_rdata[64 +: 32] = 32'hC2; s_rdata[31:0] = 32'hB1; #1;
    chk("switch s2 rvalid", m_rvalid, 1);
    chk("switch s2 rdata", m_rdata, 32'hC2);
    @(negedge clk); s_rvalid = '0; #1;
    chk("switch drained", outstanding, 0);

    // Hung slave 1: watchdog errors it out, or the bus stays stalled.
    @(negedge clk); rst = 1'b1; #1;
    chk("rst clears fault", bus_fault, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); m_req = 1'b1; m_addr = 32'h204; s_gnt = 5'h02; #1;
    chk("hang gnt", m_gnt, 1);
    first = 0; to_err = 1'b0; to_rdata = '1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); m_req = 1'b0;
`ifdef BUS_TIMEOUT_EN
      s_rvalid = (k == 12) ? 5'h02 : 5'h00;
      s_rdata[32 +: 32] = 32'h5555AAAA;
`endif
      #1;
      if (m_rvalid && first == 0) begin
        first = k; to_err = m_err; to_rdata = m_rdata;
      end
`ifdef BUS_TIMEOUT_EN
      if (k == 12) chk("late rvalid dropped", m_rvalid, 0);
`endif
    end
    s_rvalid = '0;
`ifdef BUS_TIMEOUT_EN
    chk("timeout cycle", first, 8);
    chk("timeout err", to_err, 1);
    chk("timeout rdata", to_rdata, 0);
    chk("timeout fault", bus_fault, 1);
    chk("timeout outstanding", outstanding, 0);
`else
    chk("hung no rvalid", first, 0);
    chk("hung outstanding", outstanding, 1);
`endif

    // Reset with two entries outstanding and the fault flag set.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); m_req = 1'b1; m_addr = 32'h9000; #1;
    chk("rst err gnt", m_gnt, 1);
    @(negedge clk); m_req = 1'b0; #1;
    @(negedge clk); m_req = 1'b1; m_addr = 32'h400; s_gnt = 5'h1f; #1;
    chk("rst fault set", bus_fault, 1);
    chk("rst gnt a", m_gnt, 1);
    @(negedge clk); #1;
    chk("rst gnt b", m_gnt, 1);
    @(negedge clk); m_req = 1'b0; #1;
    chk("rst pre outstanding", outstanding, 2);
    #1 rst = 1'b1;
    #1;
    chk("rst async outstanding", outstanding, 0);
    chk("rst async fault", bus_fault, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); s_rvalid = 5'h01; s_rdata[31:0] = 32'hBAD; #1;
    chk("rst stray rvalid", m_rvalid, 0);
    chk("rst stray rdata", m_rdata, 0);
    chk("rst stray outstanding", outstanding, 0);
    s_rvalid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
